// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btb_pkg
//  Description : Shared types and helpers for the branch target buffer.
//                Entry fields are stored at their maximum widths. The top
//                level zero-extends PCs and targets into them and uses only
//                CNT_W counter bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

  // Storage widths of the entry fields (upper bounds for ADDR_W / CNT_W)
  localparam int BTB_ADDR_W = 64;
  localparam int BTB_CNT_W  = 8;

  typedef struct packed {
    logic                  valid;
    logic [BTB_ADDR_W-1:0] pc;
    logic [BTB_ADDR_W-1:0] target;
    logic [BTB_CNT_W-1:0]  cnt;
  } btb_entry_t;

  // Per-slot update classification
  typedef enum logic [2:0] {
    NONE     = 3'd0,
    INC      = 3'd1,
    RETARGET = 3'd2,
    ALLOC    = 3'd3,
    DEC      = 3'd4
  } btb_act_e;

  // Confidence assigned on allocation or retarget: 2^(cnt_w-1)
  function automatic logic [BTB_CNT_W-1:0] cnt_init(input int cnt_w);
    return BTB_CNT_W'(1) << (cnt_w - 1);
  endfunction

  // Saturation value: 2^cnt_w - 1
  function automatic logic [BTB_CNT_W-1:0] cnt_max(input int cnt_w);
    return (BTB_CNT_W'(1) << cnt_w) - BTB_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_repl.sv
`default_nettype none
// ============================================================================
//  Module      : btb_repl
//  Description : Replacement state for the branch target buffer. It supplies
//                two victims per cycle and absorbs two updates per cycle, in
//                slot order.
//                BTB_LRU_EN defined   : true LRU with per-way ages.
//                BTB_LRU_EN undefined : round-robin pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_repl #(
  parameter  int WAYS  = 16,
  localparam int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
`ifdef BTB_LRU_EN
  input  logic             touch1_en,
  input  logic [IDX_W-1:0] touch1_way,
  input  logic             touch2_en,
  input  logic [IDX_W-1:0] touch2_way,
`else
  input  logic             adv1,
  input  logic             adv2,
`endif
  output logic [IDX_W-1:0] victim1,
  output logic [IDX_W-1:0] victim2
);

`ifdef BTB_LRU_EN
  typedef logic [WAYS-1:0][IDX_W-1:0] age_t;

  age_t age_q, age_mid, age_d;

  function automatic age_t ages_reset();
    age_t r;
    for (int i = 0; i < WAYS; i++) r[i] = IDX_W'(i);
    return r;
  endfunction

  // Touched way becomes youngest; only ways younger than it age by one
  function automatic age_t touch(input age_t a, input logic [IDX_W-1:0] w);
    age_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (IDX_W'(i) == w)     r[i] = '0;
      else if (a[i] < a[w])   r[i] = a[i] + IDX_W'(1);
    end
    return r;
  endfunction

  // Ages form a permutation, so the maximum is unique
  function automatic logic [IDX_W-1:0] oldest(input age_t a);
    logic [IDX_W-1:0] best;
    best = '0;
    for (int i = 1; i < WAYS; i++) begin
      if (a[i] > a[best]) best = IDX_W'(i);
    end
    return best;
  endfunction

  assign victim1 = oldest(age_q);

  // Slot 2 sees the ages after slot 1's touch
  always_comb begin
    age_mid = age_q;
    if (touch1_en) age_mid = touch(age_q, touch1_way);
    victim2 = oldest(age_mid);
  end

  // Next ages: slot 2 touch on top of slot 1, clear restores the reset order
  always_comb begin
    age_d = age_mid;
    if (touch2_en) age_d = touch(age_mid, touch2_way);
    if (clear)     age_d = ages_reset();
  end

  // Age register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= ages_reset();
    else        age_q <= age_d;
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign victim1 = ptr_q;
  assign victim2 = ptr_q + IDX_W'(adv1);

  // Pointer advances once per victim-based allocation
  always_comb begin
    ptr_d = ptr_q + IDX_W'(adv1) + IDX_W'(adv2);
    if (clear) ptr_d = '0;
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Fully-associative dual-ported BTB with saturating confidence
//                counters. Two registered lookups and two in-order training
//                updates per cycle. Replacement policy: BTB_LRU_EN (true LRU)
//                or round-robin when undefined. ADDR_W <= 64, CNT_W <= 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int WAYS   = 16,
  parameter int CNT_W  = 2,
  parameter int ADDR_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enableE,
  input  logic                       StallE,
  input  logic                       clear,
  input  logic [ADDR_W-1:0]          PCF1,
  input  logic [ADDR_W-1:0]          PCF2,
  output logic                       HitF1,
  output logic                       HitF2,
  output logic                       TakenF1,
  output logic                       TakenF2,
  output logic [ADDR_W-1:0]          TargetF1,
  output logic [ADDR_W-1:0]          TargetF2,
  input  logic                       UpdValidE1,
  input  logic                       UpdValidE2,
  input  logic [ADDR_W-1:0]          UpdPCE1,
  input  logic [ADDR_W-1:0]          UpdPCE2,
  input  logic [ADDR_W-1:0]          UpdTargetE1,
  input  logic [ADDR_W-1:0]          UpdTargetE2,
  input  logic                       UpdTakenE1,
  input  logic                       UpdTakenE2,
  output logic [$clog2(WAYS+1)-1:0]  Occupancy
);

  localparam int IDX_W = $clog2(WAYS);
  localparam int OCC_W = $clog2(WAYS+1);

  typedef btb_entry_t tbl_t [WAYS];

  tbl_t tbl_q, tbl_mid, tbl_new, tbl_d;

  logic                  commit1, commit2;
  logic [BTB_ADDR_W-1:0] pc1_x, pc2_x, tgt1_x, tgt2_x;
  logic [IDX_W:0]        match1, match2, free1, free2;
  btb_act_e              act1, act2;
  logic [IDX_W-1:0]      way1, way2, victim1, victim2;
  logic [OCC_W-1:0]      occ_d, occ_q;

  logic [IDX_W:0]        lk1, lk2;
  logic                  hitf1_d, hitf2_d, hitf1_q, hitf2_q;
  logic                  takenf1_d, takenf2_d, takenf1_q, takenf2_q;
  logic [ADDR_W-1:0]     targetf1_d, targetf2_d, targetf1_q, targetf2_q;

  // {found, way} of the lowest-index valid entry holding pc
  function automatic logic [IDX_W:0] find_pc(input tbl_t t, input logic [BTB_ADDR_W-1:0] pc);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (t[i].valid && t[i].pc == pc) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  // {found, way} of the lowest-index invalid entry
  function automatic logic [IDX_W:0] find_free(input tbl_t t);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!t[i].valid) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  function automatic btb_act_e decide(input logic hit, input btb_entry_t e, input logic taken,
                                      input logic [BTB_ADDR_W-1:0] tgt);
    if (taken) begin
      if (!hit)             return ALLOC;
      else if (e.target == tgt) return INC;
      else                  return RETARGET;
    end
    return hit ? DEC : NONE;
  endfunction

  function automatic btb_entry_t apply(input btb_act_e a, input btb_entry_t e,
                                       input logic [BTB_ADDR_W-1:0] pc,
                                       input logic [BTB_ADDR_W-1:0] tgt);
    btb_entry_t r;
    r = e;
    case (a)
      INC:      if (e.cnt != cnt_max(CNT_W)) r.cnt = e.cnt + BTB_CNT_W'(1);
      RETARGET: begin
        r.target = tgt;
        r.cnt    = cnt_init(CNT_W);
      end
      ALLOC:    begin
        r.valid  = 1'b1;
        r.pc     = pc;
        r.target = tgt;
        r.cnt    = cnt_init(CNT_W);
      end
      DEC:      begin
        r.cnt = e.cnt - BTB_CNT_W'(1);
        if (r.cnt == '0) r.valid = 1'b0;
      end
      default:  ;
    endcase
    return r;
  endfunction

  assign commit1 = UpdValidE1 & enableE & ~StallE;
  assign commit2 = UpdValidE2 & enableE & ~StallE;
  assign pc1_x   = BTB_ADDR_W'(UpdPCE1);
  assign pc2_x   = BTB_ADDR_W'(UpdPCE2);
  assign tgt1_x  = BTB_ADDR_W'(UpdTargetE1);
  assign tgt2_x  = BTB_ADDR_W'(UpdTargetE2);

  // Slot 1 against the pre-cycle table; dropped when slot 2 targets the same PC
  always_comb begin
    match1 = find_pc(tbl_q, pc1_x);
    free1  = find_free(tbl_q);
    act1   = NONE;
    if (commit1 && !(commit2 && (UpdPCE1 == UpdPCE2)))
      act1 = decide(match1[IDX_W], tbl_q[match1[IDX_W-1:0]], UpdTakenE1, tgt1_x);
    way1 = match1[IDX_W-1:0];
    if (act1 == ALLOC) way1 = free1[IDX_W] ? free1[IDX_W-1:0] : victim1;
    tbl_mid = tbl_q;
    if (act1 != NONE) tbl_mid[way1] = apply(act1, tbl_q[way1], pc1_x, tgt1_x);
  end

  // Slot 2 in program order, on top of slot 1's result
  always_comb begin
    match2 = find_pc(tbl_mid, pc2_x);
    free2  = find_free(tbl_mid);
    act2   = NONE;
    if (commit2)
      act2 = decide(match2[IDX_W], tbl_mid[match2[IDX_W-1:0]], UpdTakenE2, tgt2_x);
    way2 = match2[IDX_W-1:0];
    if (act2 == ALLOC) way2 = free2[IDX_W] ? free2[IDX_W-1:0] : victim2;
    tbl_new = tbl_mid;
    if (act2 != NONE) tbl_new[way2] = apply(act2, tbl_mid[way2], pc2_x, tgt2_x);
  end

  // Clear overrides all updates; occupancy follows the next valid vector
  always_comb begin
    tbl_d = tbl_new;
    if (clear) begin
      for (int i = 0; i < WAYS; i++) tbl_d[i] = '0;
    end
    occ_d = '0;
    for (int i = 0; i < WAYS; i++) occ_d = occ_d + OCC_W'(tbl_d[i].valid);
  end

`ifdef BTB_LRU_EN
  logic touch1, touch2;
  assign touch1 = act1 inside {INC, RETARGET, ALLOC};
  assign touch2 = act2 inside {INC, RETARGET, ALLOC};

  btb_repl #(.WAYS(WAYS)) u_repl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .touch1_en  (touch1),
    .touch1_way (way1),
    .touch2_en  (touch2),
    .touch2_way (way2),
    .victim1    (victim1),
    .victim2    (victim2)
  );
`else
  logic adv1, adv2;
  assign adv1 = (act1 == ALLOC) & ~free1[IDX_W];
  assign adv2 = (act2 == ALLOC) & ~free2[IDX_W];

  btb_repl #(.WAYS(WAYS)) u_repl (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .adv1    (adv1),
    .adv2    (adv2),
    .victim1 (victim1),
    .victim2 (victim2)
  );
`endif

  // Lookups read the pre-edge table; miss forces taken/target to zero
  always_comb begin
    lk1        = find_pc(tbl_q, BTB_ADDR_W'(PCF1));
    lk2        = find_pc(tbl_q, BTB_ADDR_W'(PCF2));
    hitf1_d    = lk1[IDX_W];
    hitf2_d    = lk2[IDX_W];
    takenf1_d  = lk1[IDX_W] & tbl_q[lk1[IDX_W-1:0]].cnt[CNT_W-1];
    takenf2_d  = lk2[IDX_W] & tbl_q[lk2[IDX_W-1:0]].cnt[CNT_W-1];
    targetf1_d = lk1[IDX_W] ? ADDR_W'(tbl_q[lk1[IDX_W-1:0]].target) : '0;
    targetf2_d = lk2[IDX_W] ? ADDR_W'(tbl_q[lk2[IDX_W-1:0]].target) : '0;
  end

  // Table, occupancy and lookup result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WAYS; i++) tbl_q[i] <= '0;
      occ_q      <= '0;
      hitf1_q    <= 1'b0;
      hitf2_q    <= 1'b0;
      takenf1_q  <= 1'b0;
      takenf2_q  <= 1'b0;
      targetf1_q <= '0;
      targetf2_q <= '0;
    end else begin
      tbl_q      <= tbl_d;
      occ_q      <= occ_d;
      hitf1_q    <= hitf1_d;
      hitf2_q    <= hitf2_d;
      takenf1_q  <= takenf1_d;
      takenf2_q  <= takenf2_d;
      targetf1_q <= targetf1_d;
      targetf2_q <= targetf2_d;
    end
  end

  assign HitF1     = hitf1_q;
  assign HitF2     = hitf2_q;
  assign TakenF1   = takenf1_q;
  assign TakenF2   = takenf2_q;
  assign TargetF1  = targetf1_q;
  assign TargetF2  = targetf2_q;
  assign Occupancy = occ_q;

endmodule
`default_nettype wire
